// File: rtl/fence_sequencer_pkg.sv
// fence_sequencer_pkg: fence request types, sequencer states and drain routing helper.
package fence_sequencer_pkg;
  typedef enum logic [1:0] {
    FT_FENCE        = 2'd0,
    FT_FENCE_I      = 2'd1,
    FT_SFENCE_VMA   = 2'd2,
    FT_FLUSH_DCACHE = 2'd3
  } fence_type_e;
  typedef enum logic [2:0] {
    S_IDLE,
    S_DRAIN,
    S_DFLUSH,
    S_IFLUSH,
    S_TLBFLUSH,
    S_DONE
  } fence_seq_state_e;
  function automatic fence_seq_state_e drain_next(input fence_type_e t);
    return t == FT_SFENCE_VMA ? S_TLBFLUSH : S_DFLUSH;
  endfunction
endpackage

// File: rtl/fence_seq_timer.sv
// fence_seq_timer: saturating up-counter with synchronous clear, enable and terminal-count flag.
module fence_seq_timer #(
  parameter int unsigned    W   = 8,
  parameter logic [W-1:0]   MAX = '1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] count_o,
  output logic         tc_o
);
  logic [W-1:0] count_d, count_q;
  assign tc_o    = count_q == MAX;
  assign count_o = count_q;
  always_comb count_d = clr_i ? '0 : (en_i && !tc_o) ? count_q + 1'b1 : count_q;
  always_ff @(posedge clk_i) count_q <= rst_i ? '0 : count_d;
endmodule

// File: rtl/fence_sequencer.sv
// fence_sequencer: sequences drain, D$ flush, I$/TLB flush and pipeline flush for retired fences.
// Optional busy-cycle counter on perf_cycles_o when FENCE_SEQ_PERF_EN is defined.
module fence_sequencer
  import fence_sequencer_pkg::*;
#(
  parameter int unsigned DRAIN_TIMEOUT = 1024,
  parameter int unsigned CNT_W         = $clog2(DRAIN_TIMEOUT + 1)
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  input  logic [1:0]  req_type_i,
  output logic        req_ready_o,
  input  logic        halt_i,
  input  logic        no_st_pending_i,
  output logic        dcache_flush_o,
  input  logic        dcache_flush_ack_i,
  output logic        icache_flush_o,
  output logic        tlb_flush_o,
  output logic        flush_pipeline_o,
  output logic        done_o,
  output logic        busy_o,
  output logic        timeout_o,
  output logic [31:0] perf_cycles_o
);
  fence_seq_state_e state_d, state_q;
  fence_type_e      type_d, type_q;
  logic             timeout_d, timeout_q;
  logic [CNT_W-1:0] cnt;
  logic             cnt_tc, accept, drain_wait;
  assign req_ready_o      = state_q == S_IDLE && !halt_i;
  assign accept           = req_ready_o && req_valid_i;
  assign drain_wait       = state_q == S_DRAIN && !no_st_pending_i;
  assign dcache_flush_o   = state_q == S_DFLUSH;
  assign icache_flush_o   = state_q == S_IFLUSH;
  assign tlb_flush_o      = state_q == S_TLBFLUSH;
  assign done_o           = state_q == S_DONE;
  assign flush_pipeline_o = state_q == S_DONE;
  assign busy_o           = state_q != S_IDLE;
  assign timeout_o        = timeout_q;
  fence_seq_timer #(.W(CNT_W), .MAX(CNT_W'(DRAIN_TIMEOUT))) u_drain (
    .clk_i, .rst_i, .clr_i(accept), .en_i(drain_wait), .count_o(cnt), .tc_o(cnt_tc)
  );
  always_comb begin
    state_d   = state_q;
    type_d    = accept ? fence_type_e'(req_type_i) : type_q;
    // flag is visible in the cycle the counter holds DRAIN_TIMEOUT-1
    timeout_d = accept ? 1'b0
              : timeout_q | cnt_tc | (drain_wait && cnt == CNT_W'(DRAIN_TIMEOUT - 2));
    case (state_q)
      S_IDLE:     state_d = accept ? S_DRAIN : S_IDLE;
      S_DRAIN:    state_d = no_st_pending_i ? drain_next(type_q) : S_DRAIN;
      S_DFLUSH:   state_d = !dcache_flush_ack_i ? S_DFLUSH : type_q == FT_FENCE_I ? S_IFLUSH : S_DONE;
      S_IFLUSH,
      S_TLBFLUSH: state_d = S_DONE;
      default:    state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      type_q    <= FT_FENCE;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      type_q    <= type_d;
      timeout_q <= timeout_d;
    end
  end
`ifdef FENCE_SEQ_PERF_EN
  logic [31:0] perf_cnt;
  logic        perf_tc;
  fence_seq_timer #(.W(32)) u_perf (
    .clk_i, .rst_i, .clr_i(1'b0), .en_i(busy_o), .count_o(perf_cnt), .tc_o(perf_tc)
  );
  assign perf_cycles_o = perf_cnt | {32{perf_tc}};
`else
  assign perf_cycles_o = '0;
`endif
endmodule

// File: tb/tb_fence_sequencer.sv
// tb_fence_sequencer: table-driven and randomized transaction checks against a timeline model.
module tb_fence_sequencer;
  localparam int DT = 8;
  logic        clk_i = 1'b0;
  logic        rst_i, req_valid_i, halt_i, no_st_pending_i, dcache_flush_ack_i;
  logic [1:0]  req_type_i;
  logic        req_ready_o, dcache_flush_o, icache_flush_o, tlb_flush_o;
  logic        flush_pipeline_o, done_o, busy_o, timeout_o;
  logic [31:0] perf_cycles_o;
  int          checks = 0, errors = 0;
  bit          exp_to = 1'b0;
  int unsigned perf_m = 0;
  typedef struct {
    logic [1:0] t;
    int         d;
    int         a;
    int         hc;
    int         exp_done;
    bit         exp_to;
  } vec_t;
  vec_t vecs[10];
  always #5 clk_i = ~clk_i;
  fence_sequencer #(.DRAIN_TIMEOUT(DT)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_valid_i(req_valid_i), .req_type_i(req_type_i),
    .req_ready_o(req_ready_o), .halt_i(halt_i), .no_st_pending_i(no_st_pending_i),
    .dcache_flush_o(dcache_flush_o), .dcache_flush_ack_i(dcache_flush_ack_i),
    .icache_flush_o(icache_flush_o), .tlb_flush_o(tlb_flush_o),
    .flush_pipeline_o(flush_pipeline_o), .done_o(done_o), .busy_o(busy_o),
    .timeout_o(timeout_o), .perf_cycles_o(perf_cycles_o)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic chk_perf();
`ifdef FENCE_SEQ_PERF_EN
    chk("perf", perf_cycles_o, perf_m);
`else
    chk("perf", perf_cycles_o, 32'd0);
`endif
  endtask
  task automatic run_txn(input logic [1:0] t, input int d, input int a, input int hc,
                         output int done_at, output bit to_at_done);
    bit sf, fi;
    int ds, edone;
    sf    = t == 2'd2;
    fi    = t == 2'd1;
    ds    = d + 2;
    edone = sf ? d + 3 : d + 3 + a + (fi ? 1 : 0);
    for (int h = 0; h < hc; h++) begin
      @(negedge clk_i);
      req_valid_i = 1'b1; req_type_i = t; halt_i = 1'b1;
      no_st_pending_i = 1'($urandom); dcache_flush_ack_i = 1'($urandom);
      #1;
      chk("halt_ready", req_ready_o, 0);
      chk("halt_busy", busy_o, 0);
      chk("halt_timeout", timeout_o, exp_to);
      chk_perf();
    end
    @(negedge clk_i);
    req_valid_i = 1'b1; req_type_i = t; halt_i = 1'b0;
    no_st_pending_i = 1'($urandom); dcache_flush_ack_i = 1'($urandom);
    #1;
    chk("accept_ready", req_ready_o, 1);
    chk("accept_busy", busy_o, 0);
    chk("accept_timeout", timeout_o, exp_to);
    chk_perf();
    done_at = -1;
    for (int c = 1; c <= edone; c++) begin
      @(negedge clk_i);
      req_valid_i = 1'($urandom); req_type_i = 2'($urandom); halt_i = 1'($urandom);
      no_st_pending_i    = (c <= d + 1) ? (c > d) : 1'($urandom);
      dcache_flush_ack_i = (!sf && c >= ds && c <= ds + a) ? (c == ds + a) : 1'($urandom);
      #1;
      chk("busy", busy_o, 1);
      chk("ready", req_ready_o, 0);
      chk("dcache_flush", dcache_flush_o, !sf && c >= ds && c <= ds + a);
      chk("icache_flush", icache_flush_o, fi && c == ds + a + 1);
      chk("tlb_flush", tlb_flush_o, sf && c == ds);
      chk("done", done_o, c == edone);
      chk("flush_pipeline", flush_pipeline_o, c == edone);
      chk("timeout", timeout_o, d >= DT - 1 && c >= DT);
      chk_perf();
      perf_m++;
      if (done_o && done_at < 0) done_at = c;
    end
    to_at_done = timeout_o;
    exp_to     = d >= DT - 1;
  endtask
  initial begin
    int  done_at;
    bit  to_at;
    vecs[0] = '{2'd0,  0, 0, 0,  3, 1'b0};
    vecs[1] = '{2'd1,  5, 2, 0, 11, 1'b0};
    vecs[2] = '{2'd2,  0, 0, 0,  3, 1'b0};
    vecs[3] = '{2'd3,  0, 0, 0,  3, 1'b0};
    vecs[4] = '{2'd0, 20, 0, 0, 23, 1'b1};
    vecs[5] = '{2'd0,  7, 1, 0, 11, 1'b1};
    vecs[6] = '{2'd0,  6, 0, 0,  9, 1'b0};
    vecs[7] = '{2'd0,  0, 0, 4,  3, 1'b0};
    vecs[8] = '{2'd2,  3, 0, 0,  6, 1'b0};
    vecs[9] = '{2'd1,  0, 0, 0,  4, 1'b0};
    rst_i = 1'b1; req_valid_i = 1'b0; req_type_i = 2'd0; halt_i = 1'b1;
    no_st_pending_i = 1'b0; dcache_flush_ack_i = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    #1;
    chk("reset_ready_halted", req_ready_o, 0);
    chk("reset_busy", busy_o, 0);
    halt_i = 1'b0;
    #1;
    chk("reset_ready", req_ready_o, 1);
    chk("reset_outputs", {dcache_flush_o, icache_flush_o, tlb_flush_o, flush_pipeline_o, done_o, timeout_o}, 0);
    chk_perf();
    rst_i = 1'b0;
    foreach (vecs[i]) begin
      run_txn(vecs[i].t, vecs[i].d, vecs[i].a, vecs[i].hc, done_at, to_at);
      chk($sformatf("vec%0d_done_cycle", i), done_at, vecs[i].exp_done);
      chk($sformatf("vec%0d_timeout", i), to_at, vecs[i].exp_to);
    end
    @(negedge clk_i);
    req_valid_i = 1'b1; req_type_i = 2'd0; halt_i = 1'b0; no_st_pending_i = 1'b1; dcache_flush_ack_i = 1'b0;
    #1;
    chk("rst_seq_accept", req_ready_o, 1);
    @(negedge clk_i);
    req_valid_i = 1'b0;
    #1;
    chk("rst_seq_drain_busy", busy_o, 1);
    @(negedge clk_i);
    rst_i = 1'b1;
    #1;
    chk("rst_seq_dflush", dcache_flush_o, 1);
    perf_m = 0;
    exp_to = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b0; dcache_flush_ack_i = 1'b1;
    #1;
    chk("rst_seq_busy", busy_o, 0);
    chk("rst_seq_ready", req_ready_o, 1);
    chk("rst_seq_outputs", {dcache_flush_o, icache_flush_o, tlb_flush_o, flush_pipeline_o, done_o, timeout_o}, 0);
    chk_perf();
    @(negedge clk_i);
    dcache_flush_ack_i = 1'b0;
    #1;
    chk("stray_ack_busy", busy_o, 0);
    chk("stray_ack_outputs", {dcache_flush_o, icache_flush_o, tlb_flush_o, flush_pipeline_o, done_o}, 0);
    chk_perf();
    for (int n = 0; n < 40; n++) begin
      logic [1:0] t;
      int d, a, hc, exp_done;
      t  = 2'($urandom_range(0, 3));
      d  = int'($urandom_range(0, 12));
      a  = int'($urandom_range(0, 4));
      hc = int'($urandom_range(0, 2));
      exp_done = (t == 2'd2) ? d + 3 : d + 3 + a + (t == 2'd1 ? 1 : 0);
      run_txn(t, d, a, hc, done_at, to_at);
      chk("rand_done_cycle", done_at, exp_done);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
